// File: rtl/data_mem_arbiter_if.sv
// Bus bundle for the two-port data memory arbiter:
// requester ports A and B, the memory side and the starvation flag.
interface data_mem_arbiter_if;
  logic        a_req;
  logic        a_we;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_gnt;
  logic        a_rvalid;
  logic        a_err;
  logic [31:0] a_rdata;

  logic        b_req;
  logic        b_we;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_gnt;
  logic        b_rvalid;
  logic        b_err;
  logic [31:0] b_rdata;

  logic [31:0] mem_read_addr;
  logic [31:0] mem_write_addr;
  logic [31:0] mem_write_data;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  logic        b_starved;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_err, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_err, b_rdata,
    output mem_read_addr, mem_write_addr, mem_write_data,
    output mem_read_enable, mem_write_enable,
    input  mem_read_data,
    output b_starved
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_err, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_err, b_rdata,
    input  mem_read_addr, mem_write_addr, mem_write_data,
    input  mem_read_enable, mem_write_enable,
    output mem_read_data,
    input  b_starved
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port data memory arbiter: pipeline MEM stage (A) has priority,
// debug/loader port (B) gains priority after STARVE_LIMIT denied cycles.
module data_mem_arbiter #(
  parameter int DEPTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          rst_n,
  data_mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;

  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WW-1:0] LIMIT = WW'(STARVE_LIMIT);

  logic [1:0]    owner;
  logic [WW-1:0] b_wait;
  logic          starved;
  logic          gnt_a;
  logic          gnt_b;
  logic          any_gnt;
  logic          sel_we;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic          oob;
  logic          hit;
  logic          rd_q;
  logic          err_q;
  logic [31:0]   a_rdata_q;
  logic [31:0]   b_rdata_q;

  assign starved = (b_wait == LIMIT);
  assign gnt_a   = rst_n & bus.a_req
                 & ~(bus.b_req & starved);
  assign gnt_b   = rst_n & bus.b_req & ~gnt_a;
  assign any_gnt = gnt_a | gnt_b;

  // Select the granted port's request fields
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    unique case (1'b1)
      gnt_a: begin
        sel_we    = bus.a_we;
        sel_addr  = bus.a_addr;
        sel_wdata = bus.a_wdata;
      end
      gnt_b: begin
        sel_we    = bus.b_we;
        sel_addr  = bus.b_addr;
        sel_wdata = bus.b_wdata;
      end
      default: ;
    endcase
  end

  assign oob = (sel_addr >= 32'(DEPTH));
  assign hit = any_gnt & ~oob;

  assign bus.a_gnt = gnt_a;
  assign bus.b_gnt = gnt_b;
  assign bus.b_starved = starved;

  assign bus.mem_read_enable  = hit & ~sel_we;
  assign bus.mem_write_enable = hit & sel_we;
  assign bus.mem_read_addr    =
    (hit & ~sel_we) ? sel_addr : '0;
  assign bus.mem_write_addr   =
    (hit & sel_we) ? sel_addr : '0;
  assign bus.mem_write_data   =
    (hit & sel_we) ? sel_wdata : '0;

  // Responses go to whichever port owned the previous cycle
  assign bus.a_rvalid = (owner == OWN_A) & rd_q;
  assign bus.a_err    = (owner == OWN_A) & err_q;
  assign bus.b_rvalid = (owner == OWN_B) & rd_q;
  assign bus.b_err    = (owner == OWN_B) & err_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;

  // Track owner and register the one-cycle response flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= IDLE;
      rd_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      owner <= gnt_a ? OWN_A : (gnt_b ? OWN_B : IDLE);
      rd_q  <= any_gnt & ~sel_we;
      err_q <= any_gnt & oob;
    end
  end

  // Capture read data; out-of-range reads return zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (gnt_a & ~sel_we)
        a_rdata_q <= oob ? '0 : bus.mem_read_data;
      if (gnt_b & ~sel_we)
        b_rdata_q <= oob ? '0 : bus.mem_read_data;
    end
  end

  // Count consecutive denied B cycles, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      b_wait <= '0;
    else if (bus.b_req & ~gnt_b)
      b_wait <= starved ? b_wait : b_wait + 1'b1;
    else
      b_wait <= '0;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 32: number of valid memory words; legal addresses are 0..DEPTH-1.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: consecutive denied cycles after which port B wins priority.
REQ-003 SHALL have port clk  in  1: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have ports a_req, a_we  in  1, 1: port A (pipeline MEM stage) request and write flag.
REQ-006 SHALL have ports a_addr, a_wdata  in  32, 32: port A word address and write data.
REQ-007 SHALL have ports a_gnt, a_rvalid, a_err  out  1, 1, 1: port A grant, read-data valid, address error.
REQ-008 SHALL have port a_rdata  out  32: port A registered read data.
REQ-009 SHALL have ports b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_err, b_rdata with the same directions, widths and meanings as the A equivalents, serving the debug/loader port.
REQ-010 SHALL have ports mem_read_addr, mem_write_addr, mem_write_data  out  32: memory address and data.
REQ-011 SHALL have ports mem_read_enable, mem_write_enable  out  1: memory strobes.
REQ-012 SHALL have port mem_read_data  in  32: combinational memory read data.
REQ-013 SHALL have port b_starved  out  1: high while port B holds forced priority.

Function
REQ-014 SHALL grant at most one port per cycle; x_gnt is combinational from requests and registered state.
REQ-015 SHALL grant A by default when both request, except when b_starved=1; then B is granted.
REQ-016 SHALL grant the sole requester when only one port requests; no grant when neither does.
REQ-017 SHALL route only the granted port to the memory: read grant -> mem_read_addr=addr, mem_read_enable=1; write grant -> mem_write_addr=addr, mem_write_data=wdata, mem_write_enable=1.
REQ-018 SHALL drive all mem_* outputs to 0 when no port is granted or the granted address is >= DEPTH.
REQ-019 SHALL capture mem_read_data into x_rdata on the edge ending a granted read and pulse x_rvalid for exactly one cycle (latency 1).
REQ-020 SHALL leave x_rdata unchanged when no read completes for that port; a write grant produces no rvalid.
REQ-021 SHALL, for a granted access with addr >= DEPTH, perform no memory access, pulse x_err for one cycle on the next cycle, and for reads also pulse x_rvalid with x_rdata=0.
REQ-022 SHALL require requesters to hold req and fields stable until gnt; a request dropped before grant is discarded silently.
REQ-023 SHALL keep a 3-state FSM last_owner: IDLE, OWN_A, OWN_B, updated each edge to the port granted that cycle (IDLE if none); it selects which port receives rvalid/err.
REQ-024 SHALL count b_wait: +1 each cycle with b_req=1 and b_gnt=0, saturating at STARVE_LIMIT; cleared to 0 on b_gnt or b_req=0.
REQ-025 SHALL assert b_starved combinationally when b_wait == STARVE_LIMIT.
REQ-026 SHALL allow back-to-back grants every cycle to the same or alternating ports with no bubble.
REQ-027 SHALL, for a write then a read to the same address in consecutive cycles, return the newly written data (memory write commits on the first edge).

Reset
REQ-028 SHALL on rst_n=0, immediately and independent of clk, force FSM=IDLE, b_wait=0, all x_rvalid/x_err=0, x_rdata=0.
REQ-029 SHALL keep x_gnt and mem_* enables at 0 while rst_n=0.
REQ-030 SHALL discard any read in flight when reset asserts mid-operation; no rvalid after reset release for it.

Verification
REQ-031 SHALL pass: A reads addr 5 (mem word 6) alone -> a_gnt same cycle, next cycle a_rvalid=1, a_rdata=6.
REQ-032 SHALL pass: A and B both request continuously -> A granted 4 cycles, b_starved=1 in cycle 5, B granted cycle 5, b_wait returns to 0.
REQ-033 SHALL pass: B writes 0xDEADBEEF to addr 3, then A reads addr 3 next cycle -> a_rdata=0xDEADBEEF.
REQ-034 SHALL pass: A reads addr 40 -> mem_read_enable=0, next cycle a_rvalid=1, a_err=1, a_rdata=0.
REQ-035 SHALL pass: rst_n dropped between a granted B read and its completion edge -> b_rvalid stays 0, all outputs 0 asynchronously.
REQ-036 SHALL pass: idle cycles with no requests -> all gnt, mem enables, rvalid, err remain 0 and FSM stays IDLE.
